// File: rtl/credit_pkg.sv
// Shared operation codes and controller state encodings for the credit accumulator.
package credit_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_SUB    = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_REFUND = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/credit_accum_addsub_n.sv
// Combinational WIDTH-bit add/subtract with carry (add) or borrow (sub) out.
module addsub_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] full;

  // Zero-extended operands: the top bit of the difference is set exactly when b > a.
  always_comb begin
    if (sub) full = {1'b0, a} - {1'b0, b};
    else     full = {1'b0, a} + {1'b0, b};
  end

  assign result = full[WIDTH-1:0];
  assign carry  = full[WIDTH];

endmodule

// File: rtl/credit_accum.sv
// Credit register with checked add/sub/clear and a UNIT-chunked refund drain.
// Optional build macro CREDIT_SATURATE_EN: an ADD carry clips credit to the maximum.
module credit_accum
  import credit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int UNIT  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_val,
  output logic [WIDTH-1:0] credit,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_ok,
  output logic             resp_sat,
  output logic             refund_valid,
  input  logic             refund_ready,
  output logic [WIDTH-1:0] refund_amt
);

  localparam logic [WIDTH-1:0] UNIT_V = WIDTH'(UNIT);

  state_t           state, state_nxt;
  op_t              op;
  logic [WIDTH-1:0] credit_nxt;
  logic [WIDTH-1:0] arith_b;
  logic             arith_sub;
  logic [WIDTH-1:0] arith_res;
  logic             arith_carry;
  logic             ok_nxt;

`ifdef CREDIT_SATURATE_EN
  logic             sat_q, sat_nxt;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] sum,
                                                input logic carry);
    return carry ? {WIDTH{1'b1}} : sum;
  endfunction
`endif

  assign op           = op_t'(in_op);
  assign in_ready     = (state == ST_IDLE);
  assign resp_valid   = (state == ST_RESP);
  assign refund_valid = (state == ST_DRAIN);
  assign refund_amt   = refund_valid ? ((credit < UNIT_V) ? credit : UNIT_V) : '0;

  // One adder serves ADD/SUB in IDLE and the beat decrement in DRAIN.
  always_comb begin
    arith_b   = in_val;
    arith_sub = (op == OP_SUB);
    if (state == ST_DRAIN) begin
      arith_b   = refund_amt;
      arith_sub = 1'b1;
    end
  end

  addsub_n #(.WIDTH(WIDTH)) u_addsub (
    .a      (credit),
    .b      (arith_b),
    .sub    (arith_sub),
    .result (arith_res),
    .carry  (arith_carry)
  );

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    ok_nxt     = resp_ok;
`ifdef CREDIT_SATURATE_EN
    sat_nxt    = sat_q;
`endif
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt = ST_RESP;
`ifdef CREDIT_SATURATE_EN
          sat_nxt   = 1'b0;
`endif
          case (op)
            OP_ADD: begin
`ifdef CREDIT_SATURATE_EN
              credit_nxt = sat_add(arith_res, arith_carry);
              ok_nxt     = 1'b1;
              sat_nxt    = arith_carry;
`else
              if (!arith_carry) credit_nxt = arith_res;
              ok_nxt = !arith_carry;
`endif
            end
            OP_SUB: begin
              if (!arith_carry) credit_nxt = arith_res;
              ok_nxt = !arith_carry;
            end
            OP_CLEAR: begin
              credit_nxt = '0;
              ok_nxt     = 1'b1;
            end
            OP_REFUND: begin
              ok_nxt = 1'b1;
              if (credit != '0) state_nxt = ST_DRAIN;
            end
            default: state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_DRAIN: begin
        if (refund_ready) begin
          credit_nxt = arith_res;
          if (arith_res == '0) begin
            state_nxt = ST_RESP;
            ok_nxt    = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit  <= '0;
      resp_ok <= 1'b0;
`ifdef CREDIT_SATURATE_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      credit  <= credit_nxt;
      resp_ok <= ok_nxt;
`ifdef CREDIT_SATURATE_EN
      sat_q   <= sat_nxt;
`endif
    end
  end

`ifdef CREDIT_SATURATE_EN
  assign resp_sat = sat_q;
`else
  assign resp_sat = 1'b0;
`endif

endmodule

// File: tb/tb_credit_accum.sv
// Scoreboard bench for credit_accum: stimulus queues expected responses/beats, a monitor checks them.
module tb_credit_accum;
  import credit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = 2'd0;
  logic [7:0] in_val = 8'd0;
  logic [7:0] credit;
  logic       resp_valid;
  logic       resp_ready = 1'b1;
  logic       resp_ok;
  logic       resp_sat;
  logic       refund_valid;
  logic       refund_ready = 1'b1;
  logic [7:0] refund_amt;

  typedef struct packed {
    logic       ok;
    logic       sat;
    logic [7:0] credit;
  } resp_t;

  resp_t      resp_q[$];
  logic [7:0] beat_q[$];
  int         tests = 0;
  int         fails = 0;
  int         paid  = 0;

  credit_accum #(.WIDTH(8), .UNIT(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_val       (in_val),
    .credit       (credit),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_ok      (resp_ok),
    .resp_sat     (resp_sat),
    .refund_valid (refund_valid),
    .refund_ready (refund_ready),
    .refund_amt   (refund_amt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid && resp_ready) begin
        if (resp_q.size() == 0) check("resp_unexpected", 1, 0);
        else begin
          resp_t e;
          e = resp_q.pop_front();
          check("resp_ok", int'(resp_ok), int'(e.ok));
          check("resp_sat", int'(resp_sat), int'(e.sat));
          check("resp_credit", int'(credit), int'(e.credit));
        end
      end
      if (refund_valid && refund_ready) begin
        if (beat_q.size() == 0) check("beat_unexpected", 1, 0);
        else check("beat_amt", int'(refund_amt), int'(beat_q.pop_front()));
        paid += int'(refund_amt);
      end
    end
  end

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("idle_timeout", 0, 1);
  endtask

  // Issue one operation; e_* are the hand-computed response fields.
  task automatic do_op(input logic [1:0] op, input logic [7:0] val, input logic e_ok,
                       input logic e_sat, input logic [7:0] e_credit, input bit push_resp);
    wait_idle();
    if (push_resp) resp_q.push_back('{ok: e_ok, sat: e_sat, credit: e_credit});
    in_valid = 1'b1;
    in_op    = op;
    in_val   = val;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("in_ready_low_after_accept", int'(in_ready), 0);
    if (op != OP_REFUND) check("resp_latency", int'(resp_valid), 1);
  endtask

  initial begin
    #12;
    check("rst_credit", int'(credit), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_resp_ok", int'(resp_ok), 0);
    check("rst_refund_valid", int'(refund_valid), 0);
    rst_n = 1'b1;

    do_op(OP_ADD, 8'd7, 1'b1, 1'b0, 8'd7, 1'b1);
    do_op(OP_ADD, 8'd3, 1'b1, 1'b0, 8'd10, 1'b1);
    do_op(OP_SUB, 8'd12, 1'b0, 1'b0, 8'd10, 1'b1);
    do_op(OP_SUB, 8'd10, 1'b1, 1'b0, 8'd0, 1'b1);
    do_op(OP_ADD, 8'd250, 1'b1, 1'b0, 8'd250, 1'b1);
`ifdef CREDIT_SATURATE_EN
    do_op(OP_ADD, 8'd10, 1'b1, 1'b1, 8'd255, 1'b1);
`else
    do_op(OP_ADD, 8'd10, 1'b0, 1'b0, 8'd250, 1'b1);
`endif
    do_op(OP_CLEAR, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1);

    // Free-flowing refund of 13: beats 5, 5, 3.
    do_op(OP_ADD, 8'd13, 1'b1, 1'b0, 8'd13, 1'b1);
    beat_q.push_back(8'd5); beat_q.push_back(8'd5); beat_q.push_back(8'd3);
    paid = 0;
    do_op(OP_REFUND, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1);
    check("refund_valid_after_accept", int'(refund_valid), 1);
    wait_idle();
    check("refund_total", paid, 13);

    // Refund of 13 with a 3-cycle stall after the first beat.
    do_op(OP_ADD, 8'd13, 1'b1, 1'b0, 8'd13, 1'b1);
    beat_q.push_back(8'd5); beat_q.push_back(8'd5); beat_q.push_back(8'd3);
    paid = 0;
    do_op(OP_REFUND, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1);
    @(posedge clk);
    #1;
    refund_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_amt", int'(refund_amt), 5);
      check("stall_credit", int'(credit), 8);
      check("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    refund_ready = 1'b1;
    wait_idle();
    check("stall_refund_total", paid, 13);

    // Refund with zero credit: no beats, response next cycle.
    do_op(OP_REFUND, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1);
    check("zero_refund_no_beat", int'(refund_valid), 0);
    check("zero_refund_resp", int'(resp_valid), 1);

    // Reset asserted mid-drain: no beats taken, no response expected.
    do_op(OP_ADD, 8'd13, 1'b1, 1'b0, 8'd13, 1'b1);
    wait_idle();
    refund_ready = 1'b0;
    do_op(OP_REFUND, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    check("drain_entered", int'(refund_valid), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_credit", int'(credit), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_resp_valid", int'(resp_valid), 0);
    check("midrst_resp_ok", int'(resp_ok), 0);
    check("midrst_resp_sat", int'(resp_sat), 0);
    check("midrst_refund_valid", int'(refund_valid), 0);
    check("midrst_refund_amt", int'(refund_amt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    refund_ready = 1'b1;

    do_op(OP_ADD, 8'd4, 1'b1, 1'b0, 8'd4, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("resp_queue_empty", resp_q.size(), 0);
    check("beat_queue_empty", beat_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
